mul_div_unit: RTL

- Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) with architectural HI/LO registers.
- Sits in the EX stage beside ALU32bit and takes the same A/B operands. HI/LO feed the writeback mux for MFHI/MFLO.
- The pipeline stalls on busy. ALU32bit is never stalled by this block.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_step.sv | 29 ++
 rtl/mul_div_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
// The MDU_EARLY_OUT_EN build option is consumed by mul_div_unit.
package mdu_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_RUN  = 2'b10,
    ST_FIX  = 2'b11
  } state_e;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on the 64-bit accumulator: shift-add for multiply,
// restoring shift-subtract for divide.
module mdu_step
  import mdu_pkg::*;
(
  input  logic                is_div_i,
  input  logic [2*DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0]   m_i,
  output logic [2*DATA_W-1:0] acc_o
);
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   rem;
  logic [DATA_W:0]   diff;
  logic [2*DATA_W:0] sh;

  always_comb begin
    sum  = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + (acc_i[0] ? {1'b0, m_i} : '0);
    sh   = {acc_i, 1'b0};
    rem  = sh[2*DATA_W:DATA_W];
    // partial remainder stays below 2*divisor, so diff's top bit is the borrow
    diff = rem - {1'b0, m_i};
    if (!is_div_i)
      acc_o = {sum, acc_i[DATA_W-1:1]};
    else if (!diff[DATA_W])
      acc_o = {diff[DATA_W-1:0], sh[DATA_W-1:1], 1'b1};
    else
      acc_o = sh[2*DATA_W-1:0];
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO: IDLE -> PREP -> RUN x32 -> FIX.
// Define MDU_EARLY_OUT_EN to let multiplies leave RUN once the multiplier is exhausted.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              flush,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  state_e              state_q;
  op_e                 op_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   a_q, m_q, hi_q, lo_q;
  logic [2*DATA_W-1:0] acc_q, acc_step, prod;
  logic                neg_q, sa_q, dz_q, done_q, dz_out_q;
  logic                is_div, sgn_op, sa, sb;
  logic [DATA_W-1:0]   q_fix, r_fix;

  mdu_step u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .m_i      (m_q),
    .acc_o    (acc_step)
  );

  always_comb begin
    is_div = op_q[1];
    sgn_op = ~op_q[0];
    sa     = sgn_op & a_q[DATA_W-1];
    sb     = sgn_op & m_q[DATA_W-1];
    prod   = neg_q ? -acc_q : acc_q;
    q_fix  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    r_fix  = sa_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  end

`ifdef MDU_EARLY_OUT_EN
  logic [DATA_W-1:0]  rem_mask;
  logic [CNT_W+1:0]   rem_sh;
  // multiplier bits not yet consumed sit in acc_q[DATA_W-1-cnt:0]
  assign rem_mask = {DATA_W{1'b1}} >> cnt_q;
  assign rem_sh   = (CNT_W+2)'(DATA_W) - (CNT_W+2)'(cnt_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      a_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      if (state_q != ST_IDLE && flush) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
            // a flush in the same cycle suppresses the launch
            if (start && !flush) begin
              op_q    <= op_e'(op);
              a_q     <= A;
              m_q     <= B;
              state_q <= ST_PREP;
            end
          end
          ST_PREP: begin
            neg_q   <= sa ^ sb;
            sa_q    <= sa;
            dz_q    <= is_div && (m_q == '0);
            acc_q   <= {{DATA_W{1'b0}}, is_div ? mag(a_q, sa) : mag(m_q, sb)};
            m_q     <= is_div ? mag(m_q, sb) : mag(a_q, sa);
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
          ST_RUN: begin
            cnt_q <= cnt_q + CNT_W'(1);
`ifdef MDU_EARLY_OUT_EN
            if (!is_div && (acc_q[DATA_W-1:0] & rem_mask) == '0) begin
              acc_q   <= acc_q >> rem_sh;
              state_q <= ST_FIX;
            end else
`endif
            begin
              acc_q <= acc_step;
              if (cnt_q == CNT_W'(DATA_W-1)) state_q <= ST_FIX;
            end
          end
          ST_FIX: begin
            if (dz_q) begin
              hi_q <= a_q;
              lo_q <= '1;
            end else if (is_div) begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end else begin
              hi_q <= prod[2*DATA_W-1:DATA_W];
              lo_q <= prod[DATA_W-1:0];
            end
            done_q   <= 1'b1;
            dz_out_q <= dz_q;
            state_q  <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign div_zero = dz_out_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule
